// File: rtl/axis_stream_checker_pkg.sv
// Shared constants for the AXI-Stream checker: FSM state encoding, default
// parameter values and the throttle period.
package axis_stream_checker_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_PKT_LEN     = 16;
  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned THROTTLE_PERIOD = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI-Stream beat bundle. The producer (memory stage m03 master) uses the
// master modport; the checker consumes it through the slave modport.
interface axis_stream_checker_if
  import axis_stream_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module axis_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones, zero on clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream packet checker: consumes the memory stage's m03 stream, checks an
// incrementing data pattern, strobes and packet framing, and keeps statistics.
// Optional build macro: AXIS_CHECKER_THROTTLE_EN drops tready 1 cycle in 8 in RUN.
module axis_stream_checker
  import axis_stream_checker_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned           PKT_LEN     = DEF_PKT_LEN,
  parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
  parameter int unsigned           CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic                  s00_axis_enable,
  input  logic                  s00_axis_clear,
  axis_stream_checker_if.slave  s00_axis,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  err_flag
);

  localparam int unsigned      IDX_W    = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  state_t                state_q, state_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [DATA_WIDTH-1:0] first_err_q, first_err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_flag_q, err_flag_d;
  logic                  accept, at_last, beat_err;

  assign accept   = s00_axis.tvalid & tready_q;
  assign at_last  = (idx_q == LAST_IDX);
  assign beat_err = (s00_axis.tdata != exp_q) | (s00_axis.tstrb != '1) |
                    (s00_axis.tlast != at_last);

  // Next checker state: clear re-arms everything; otherwise react to accepted beats.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    err_flag_d  = err_flag_q;
    first_err_d = first_err_q;
    if (s00_axis_clear) begin
      state_d     = ST_IDLE;
      exp_d       = START_VALUE;
      idx_d       = '0;
      err_flag_d  = 1'b0;
      first_err_d = '0;
    end else begin
      if (accept) begin
        // A good beat has tdata == expected, so tdata+1 covers both the
        // normal increment and the resync after an error.
        exp_d = s00_axis.tdata + DATA_WIDTH'(1);
        idx_d = (s00_axis.tlast || at_last) ? '0 : idx_q + IDX_W'(1);
        if (beat_err) begin
          err_flag_d = 1'b1;
          if (!err_flag_q) first_err_d = s00_axis.tdata;
        end
      end
      unique case (state_q)
        ST_IDLE: if (s00_axis_enable) state_d = ST_RUN;
        ST_RUN: begin
          if (accept && s00_axis.tlast) state_d = ST_GAP;
          // Only leave RUN with no packet open so the producer is never stranded.
          else if (!s00_axis_enable && (idx_d == '0)) state_d = ST_IDLE;
        end
        ST_GAP:  state_d = s00_axis_enable ? ST_RUN : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef AXIS_CHECKER_THROTTLE_EN
  logic [3:0] thr_q;

  // Free-running throttle phase counter.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) thr_q <= '0;
    else                   thr_q <= thr_q + 4'd1;
  end

  // tready is registered, so look at the phase the counter is about to take.
  assign tready_d = (state_d == ST_RUN) &&
                    ((thr_q[2:0] + 3'd1) != 3'(THROTTLE_PERIOD - 1));
`else
  assign tready_d = (state_d == ST_RUN);
`endif

  // Checker state registers.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= ST_IDLE;
      tready_q    <= 1'b0;
      exp_q       <= START_VALUE;
      idx_q       <= '0;
      err_flag_q  <= 1'b0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      err_flag_q  <= err_flag_d;
      first_err_q <= first_err_d;
    end
  end

  axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .inc   (accept),
    .clr   (s00_axis_clear),
    .count (beat_count)
  );

  axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .inc   (accept & s00_axis.tlast),
    .clr   (s00_axis_clear),
    .count (pkt_count)
  );

  axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .inc   (accept & beat_err),
    .clr   (s00_axis_clear),
    .count (err_count)
  );

  assign s00_axis.tready = tready_q;
  assign err_flag        = err_flag_q;
  assign first_err_data  = first_err_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Self-checking bench for axis_stream_checker: a beat-level reference model is
// compared against the DUT every cycle, plus literal pins of key totals.
module tb_axis_stream_checker;
  import axis_stream_checker_pkg::*;

  localparam int unsigned   DW   = 32;
  localparam int            PL   = 16;
  localparam int unsigned   CW   = 6;
  localparam logic [DW-1:0] SV   = '0;
  localparam int            CMAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [3:0]    s;
    logic          l;
  } beat_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic enable = 1'b0;
  logic clear  = 1'b0;
  logic [CW-1:0] beat_count, pkt_count, err_count;
  logic [DW-1:0] first_err_data;
  logic          err_flag;

  axis_stream_checker_if #(.DATA_WIDTH(DW)) s_if ();

  axis_stream_checker #(
    .DATA_WIDTH  (DW),
    .PKT_LEN     (PL),
    .START_VALUE (SV),
    .CNT_WIDTH   (CW)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_enable  (enable),
    .s00_axis_clear   (clear),
    .s00_axis         (s_if.slave),
    .beat_count       (beat_count),
    .pkt_count        (pkt_count),
    .err_count        (err_count),
    .first_err_data   (first_err_data),
    .err_flag         (err_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  beat_t q[$];

  // Reference model state (beat-level view of the rules).
  int            m_beats, m_pkts, m_errs, m_idx, m_mode, m_ticks;  // mode 0 idle,1 run,2 gap
  logic [DW-1:0] m_exp, m_first;
  bit            m_flag, m_tready, m_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                     input logic [63:0] lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mdl_v, lit);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic void model_reset();
    m_beats = 0; m_pkts = 0; m_errs = 0; m_idx = 0; m_mode = 0; m_ticks = 0;
    m_exp = SV; m_first = '0; m_flag = 1'b0; m_tready = 1'b0; m_acc = 1'b0;
  endfunction

  // Advance the model by one rising edge using the inputs presented at that edge.
  task automatic model_step();
    bit last_pos, bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_acc = s_if.tvalid && m_tready;
    m_ticks++;
    if (clear) begin
      m_beats = 0; m_pkts = 0; m_errs = 0; m_idx = 0; m_mode = 0;
      m_exp = SV; m_first = '0; m_flag = 1'b0;
    end else begin
      if (m_acc) begin
        last_pos = (m_idx == PL - 1);
        bad = (s_if.tdata !== m_exp) || (s_if.tstrb !== 4'hF) || (s_if.tlast !== last_pos);
        m_beats = sat(m_beats + 1);
        if (s_if.tlast) m_pkts = sat(m_pkts + 1);
        if (bad) begin
          m_errs = sat(m_errs + 1);
          if (!m_flag) m_first = s_if.tdata;
          m_flag = 1'b1;
        end
        m_exp = s_if.tdata + DW'(1);
        m_idx = (s_if.tlast || last_pos) ? 0 : m_idx + 1;
      end
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: begin
          if (m_acc && s_if.tlast) m_mode = 2;
          else if (!enable && m_idx == 0) m_mode = 0;
        end
        default: m_mode = enable ? 1 : 0;
      endcase
    end
    m_tready = (m_mode == 1);
`ifdef AXIS_CHECKER_THROTTLE_EN
    if (m_ticks % 8 == 7) m_tready = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("tready", 64'(s_if.tready), 64'(m_tready));
      check("beat_count", 64'(beat_count), 64'(m_beats));
      check("pkt_count", 64'(pkt_count), 64'(m_pkts));
      check("err_count", 64'(err_count), 64'(m_errs));
      check("err_flag", 64'(err_flag), 64'(m_flag));
      check("first_err_data", 64'(first_err_data), 64'(m_first));
    end
  end

  function automatic void push(input logic [DW-1:0] d, input logic [3:0] s, input logic l);
    beat_t b;
    b.d = d; b.s = s; b.l = l;
    q.push_back(b);
  endfunction

  function automatic void push_run(input logic [DW-1:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) push(base + DW'(i), 4'hF, (i == last_at));
  endfunction

  // Drive the queued beats; stalls counts refused valid beats once streaming began.
  task automatic send_beats(input bit gaps, output int stalls);
    int budget;
    bit started;
    budget = 4000; stalls = 0; started = 1'b0;
    while (q.size() != 0 && budget != 0) begin
      s_if.tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_if.tdata  = q[0].d;
      s_if.tstrb  = q[0].s;
      s_if.tlast  = q[0].l;
      tick();
      budget--;
      if (m_acc) begin
        void'(q.pop_front());
        started = 1'b1;
      end else if (started && s_if.tvalid) begin
        stalls++;
      end
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tstrb = '1;
    check("send_budget", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // Assert reset between clock edges and confirm outputs clear without a clock.
  task automatic pulse_reset(input int cycles);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_tready", 64'(s_if.tready), 64'd0);
    check("async_rst_beats", 64'(beat_count), 64'd0);
    check("async_rst_pkts", 64'(pkt_count), 64'd0);
    check("async_rst_errs", 64'(err_count), 64'd0);
    check("async_rst_flag", 64'(err_flag), 64'd0);
    check("async_rst_first", 64'(first_err_data), 64'd0);
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int            stalls;
    logic [DW-1:0] g_next, d;
    logic [3:0]    s;
    logic          l;
    int            g_idx;

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '1; s_if.tlast = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    chk_on = 1'b1;
    repeat (3) tick();
    pin("rst_beats", 64'(beat_count), 64'(m_beats), 64'd0);
    pin("rst_tready", 64'(s_if.tready), 64'(m_tready), 64'd0);
    rst_n = 1'b1;

    // Two clean packets, data 0..31.
    enable = 1'b1;
    push_run(0, 16, 15);
    push_run(16, 16, 15);
    send_beats(1'b0, stalls);
    pin("s1_beats", 64'(beat_count), 64'(m_beats), 64'd32);
    pin("s1_pkts", 64'(pkt_count), 64'(m_pkts), 64'd2);
    pin("s1_errs", 64'(err_count), 64'(m_errs), 64'd0);
    pin("s1_flag", 64'(err_flag), 64'(m_flag), 64'd0);
`ifndef AXIS_CHECKER_THROTTLE_EN
    check("s1_gap_stalls", 64'(stalls), 64'd1);
    check("s1_tready_after_last", 64'(s_if.tready), 64'd0);
    tick();
    check("s1_tready_resume", 64'(s_if.tready), 64'd1);
`endif

    // Corrupted beat 5, then the stream resyncs to 0xDEAE onward.
    pulse_reset(2);
    for (int i = 0; i < 16; i++) push((i < 5) ? DW'(i) : 32'hDEAD + DW'(i - 5), 4'hF, i == 15);
    push_run(32'hDEB8, 16, 15);
    send_beats(1'b1, stalls);
    pin("s2_errs", 64'(err_count), 64'(m_errs), 64'd1);
    pin("s2_first", 64'(first_err_data), 64'(m_first), 64'hDEAD);
    pin("s2_pkts", 64'(pkt_count), 64'(m_pkts), 64'd2);

    // Early tlast at index 9, then a clean 16-beat packet.
    pulse_reset(2);
    push_run(0, 10, 9);
    send_beats(1'b1, stalls);
    pin("s3_errs_a", 64'(err_count), 64'(m_errs), 64'd1);
    pin("s3_pkts_a", 64'(pkt_count), 64'(m_pkts), 64'd1);
    pin("s3_first", 64'(first_err_data), 64'(m_first), 64'd9);
    push_run(10, 16, 15);
    send_beats(1'b1, stalls);
    pin("s3_errs_b", 64'(err_count), 64'(m_errs), 64'd1);
    pin("s3_pkts_b", 64'(pkt_count), 64'(m_pkts), 64'd2);

    // Partial strobe, then clear together with a valid beat.
    pulse_reset(2);
    push(0, 4'hF, 1'b0); push(1, 4'h7, 1'b0); push(2, 4'hF, 1'b0);
    send_beats(1'b0, stalls);
    pin("s4_flag", 64'(err_flag), 64'(m_flag), 64'd1);
    pin("s4_first", 64'(first_err_data), 64'(m_first), 64'd1);
    clear = 1'b1; s_if.tvalid = 1'b1; s_if.tdata = 3;
    tick();
    clear = 1'b0; s_if.tvalid = 1'b0;
    pin("s4_clr_beats", 64'(beat_count), 64'(m_beats), 64'd0);
    pin("s4_clr_errs", 64'(err_count), 64'(m_errs), 64'd0);
    pin("s4_clr_flag", 64'(err_flag), 64'(m_flag), 64'd0);
    pin("s4_clr_tready", 64'(s_if.tready), 64'(m_tready), 64'd0);
    push_run(SV, 16, 15);
    send_beats(1'b1, stalls);
    pin("s4_post_errs", 64'(err_count), 64'(m_errs), 64'd0);

    // Enable drops at beat 4; the packet must still complete.
    pulse_reset(2);
    push_run(0, 4, -1);
    send_beats(1'b0, stalls);
    enable = 1'b0;
    push_run(4, 12, 11);
    send_beats(1'b0, stalls);
`ifndef AXIS_CHECKER_THROTTLE_EN
    check("s5_no_stall", 64'(stalls), 64'd0);
`endif
    tick(); tick();
    pin("s5_idle_tready", 64'(s_if.tready), 64'(m_tready), 64'd0);
    pin("s5_pkts", 64'(pkt_count), 64'(m_pkts), 64'd1);
    enable = 1'b1;
    push_run(16, 6, -1);
    send_beats(1'b0, stalls);
    pulse_reset(2);
    push_run(SV, 16, 15);
    send_beats(1'b1, stalls);
    pin("s5_restart_errs", 64'(err_count), 64'(m_errs), 64'd0);
    pin("s5_restart_beats", 64'(beat_count), 64'(m_beats), 64'd16);

    // Randomised stream long enough to saturate beat_count.
    pulse_reset(2);
    g_next = SV; g_idx = 0;
    for (int i = 0; i < 80; i++) begin
      d = ($urandom_range(0, 7) == 0) ? DW'($urandom) : g_next;
      s = ($urandom_range(0, 15) == 0) ? 4'hE : 4'hF;
      l = (g_idx == PL - 1) ^ ($urandom_range(0, 9) == 0);
      push(d, s, l);
      g_next = d + DW'(1);
      g_idx = (l || g_idx == PL - 1) ? 0 : g_idx + 1;
    end
    send_beats(1'b1, stalls);
    pin("s6_beats_sat", 64'(beat_count), 64'(m_beats), 64'(CMAX));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 70; i++) push(DW'(i), 4'h0, (i % 16) == 15);
    send_beats(1'b1, stalls);
    pin("s6_errs_sat", 64'(err_count), 64'(m_errs), 64'(CMAX));
    pin("s6_pkts", 64'(pkt_count), 64'(m_pkts), 64'd4);

`ifdef AXIS_CHECKER_THROTTLE_EN
    // Continuous valid under throttling: 64 clean beats.
    pulse_reset(2);
    for (int i = 0; i < 64; i++) push(SV + DW'(i), 4'hF, (i % 16) == 15);
    send_beats(1'b0, stalls);
    pin("s7_errs", 64'(err_count), 64'(m_errs), 64'd0);
    pin("s7_pkts", 64'(pkt_count), 64'(m_pkts), 64'd4);
`endif

    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
